// File: rtl/fir_pkg.sv
// Shared defaults, FSM state encoding and round-count helper for the FIR MAC scheduler.
package fir_pkg;

  localparam int unsigned DEF_TAPS = 3;
  localparam int unsigned DEF_NMUL = 2;
  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned DEF_CW   = 8;
  localparam int unsigned DEF_ACCW = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Number of issue rounds needed to cover all taps with the available lanes.
  function automatic int unsigned rounds(input int unsigned taps, input int unsigned nmul);
    return (taps + nmul - 1) / nmul;
  endfunction

endpackage

// File: rtl/fir_mul_lane.sv
// One registered signed multiplier lane shared across taps by the scheduler.
module fir_mul_lane
  import fir_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned CW = DEF_CW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DW-1:0]       a,
  input  logic signed [CW-1:0]       b,
  output logic signed [DW+CW-1:0]    p
);

  localparam int unsigned PW = DW + CW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= PW'(a) * PW'(b);
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-shares NMUL multiplier lanes over a TAPS-tap signed FIR and hands the
// accumulated result downstream through a valid/ready port.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter  int unsigned TAPS = DEF_TAPS,
  parameter  int unsigned NMUL = DEF_NMUL,
  parameter  int unsigned DW   = DEF_DW,
  parameter  int unsigned CW   = DEF_CW,
  parameter  int unsigned ACCW = DEF_ACCW,
  localparam int unsigned AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   in_data,
  input  logic                   cfg_we,
  output logic                   cfg_ready,
  input  logic [AW-1:0]          cfg_addr,
  input  logic signed [CW-1:0]   cfg_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic                   busy
);

  localparam int unsigned R  = rounds(TAPS, NMUL);
  localparam int unsigned RW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned PW = DW + CW;
  localparam int unsigned NP = R * NMUL;

  state_t state, state_nxt;

  logic [RW-1:0]          rnd;
  logic signed [DW-1:0]   x      [TAPS];
  logic signed [CW-1:0]   coef   [TAPS];
  logic signed [DW-1:0]   x_pad  [NP];
  logic signed [CW-1:0]   r_pad  [NP];
  logic signed [DW-1:0]   lane_a [NMUL];
  logic signed [CW-1:0]   lane_b [NMUL];
  logic signed [PW-1:0]   lane_p [NMUL];
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] lane_sum_c;
  logic                   accept_c;
  logic                   cfg_take_c;
  logic                   last_round_c;

  assign accept_c     = in_valid & in_ready;
  assign cfg_take_c   = cfg_we & cfg_ready;
  assign last_round_c = (rnd == RW'(R - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = ISSUE;
      ISSUE:   if (last_round_c) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake readiness is a pure decode of the registered state.
  always_comb begin
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    busy      = 1'b1;
    if (state == IDLE) begin
      in_ready  = 1'b1;
      cfg_ready = 1'b1;
      busy      = 1'b0;
    end
  end

  // Zero-pad taps up to a whole number of rounds so idle lanes multiply 0 by 0.
  always_comb begin
    for (int k = 0; k < NP; k++) begin
      x_pad[k] = '0;
      r_pad[k] = '0;
    end
    for (int k = 0; k < TAPS; k++) begin
      x_pad[k] = x[k];
      r_pad[k] = coef[k];
    end
  end

  always_comb begin
    for (int i = 0; i < NMUL; i++) begin
      lane_a[i] = '0;
      lane_b[i] = '0;
      for (int j = 0; j < R; j++) begin
        if (state == ISSUE && rnd == RW'(j)) begin
          lane_a[i] = x_pad[j * NMUL + i];
          lane_b[i] = r_pad[j * NMUL + i];
        end
      end
    end
  end

  for (genvar g = 0; g < NMUL; g++) begin : g_lane
    fir_mul_lane #(.DW(DW), .CW(CW)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (lane_a[g]),
      .b     (lane_b[g]),
      .p     (lane_p[g])
    );
  end

  always_comb begin
    lane_sum_c = '0;
    for (int i = 0; i < NMUL; i++) lane_sum_c = lane_sum_c + ACCW'(lane_p[i]);
  end

  // Delay line, coefficient bank, round counter, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= '0;
      end
      rnd       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (cfg_take_c) begin
        for (int k = 0; k < TAPS; k++)
          if (cfg_addr == AW'(k)) coef[k] <= cfg_data;
      end
      if (accept_c) begin
        x[0] <= in_data;
        for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
        rnd <= '0;
        acc <= '0;
      end
      case (state)
        ISSUE: begin
          rnd <= rnd + RW'(1);
          if (rnd != '0) acc <= acc + lane_sum_c;
        end
        DRAIN: begin
          out_data  <= acc + lane_sum_c;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: default build, a 16-bit accumulator build
// sharing its stimulus, and a single-lane build selected through sel1.
module tb_fir_mac_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              sel1 = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = '0;
  logic signed [7:0] cfg_data = '0;
  logic              out_ready = 1'b0;

  logic a_in_valid, a_cfg_we, n_in_valid, n_cfg_we;
  assign a_in_valid = in_valid & ~sel1;
  assign a_cfg_we   = cfg_we & ~sel1;
  assign n_in_valid = in_valid & sel1;
  assign n_cfg_we   = cfg_we & sel1;

  logic a_in_ready, a_cfg_ready, a_out_valid, a_busy;
  logic w_in_ready, w_cfg_ready, w_out_valid, w_busy;
  logic n_in_ready, n_cfg_ready, n_out_valid, n_busy;
  logic signed [17:0] a_out_data, n_out_data;
  logic signed [15:0] w_out_data;

  fir_mac_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .cfg_we(a_cfg_we), .cfg_ready(a_cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  fir_mac_scheduler #(.ACCW(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .cfg_we(a_cfg_we), .cfg_ready(w_cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_data(w_out_data), .busy(w_busy)
  );

  fir_mac_scheduler #(.NMUL(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .cfg_we(n_cfg_we), .cfg_ready(n_cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_data(n_out_data), .busy(n_busy)
  );

  logic in_ready_m, cfg_ready_m, out_valid_m, busy_m;
  logic signed [17:0] out_data_m;
  assign in_ready_m  = sel1 ? n_in_ready  : a_in_ready;
  assign cfg_ready_m = sel1 ? n_cfg_ready : a_cfg_ready;
  assign out_valid_m = sel1 ? n_out_valid : a_out_valid;
  assign busy_m      = sel1 ? n_busy      : a_busy;
  assign out_data_m  = sel1 ? n_out_data  : a_out_data;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct { int din; int exp; int exp16; } vec_t;
  vec_t vecs [5];
  vec_t ovf  [3];
  int   coef_tbl [3];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int addr, input int data);
    bit done = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_data = 8'(data);
    for (int t = 0; t < 50 && !done; t++) begin
      if (cfg_ready_m) done = 1'b1;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    if (!done) chk("cfg_write_timeout", 0, 1);
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2);
    cfg_write(0, c0); cfg_write(1, c1); cfg_write(2, c2);
  endtask

  // Waits for the accept edge, then measures latency and checks the result.
  task automatic run_sample(input string name, input int din, input int exp,
                            input int lat_exp, input bit chk16, input int exp16);
    bit acc = 1'b0;
    int lat;
    in_valid = 1'b1; in_data = 8'(din);
    for (int t = 0; t < 60 && !acc; t++) begin
      if (in_ready_m) acc = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; cfg_we = 1'b0;
    if (!acc) begin
      chk({name, "_accept_timeout"}, 0, 1);
      return;
    end
    lat = 1;
    while (!out_valid_m && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, lat_exp);
    chk({name, "_data"}, int'(out_data_m), exp);
    if (chk16) chk({name, "_data16"}, int'(w_out_data), exp16);
    if (out_ready) begin
      @(negedge clk);
      chk({name, "_valid_drop"}, int'(out_valid_m), 0);
    end
  endtask

  initial begin
    bit done;
    int got;

    vecs[0] = '{-3, -6, 0};  vecs[1] = '{9, 30, 0};  vecs[2] = '{4, -49, 0};
    vecs[3] = '{-8, 31, 0};  vecs[4] = '{2, 64, 0};
    ovf[0]  = '{-128, 16384, 16384};
    ovf[1]  = '{-128, 32768, -32768};
    ovf[2]  = '{-128, 49152, -16384};
    coef_tbl[0] = 2; coef_tbl[1] = -4; coef_tbl[2] = 7;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_out_data", int'(a_out_data), 0);
    chk("rst_in_ready", int'(a_in_ready), 1);
    chk("rst_cfg_ready", int'(a_cfg_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming with out_ready held high
    for (int k = 0; k < 3; k++) cfg_write(k, coef_tbl[k]);
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) run_sample($sformatf("stream%0d", v), vecs[v].din, vecs[v].exp, 4, 1'b0, 0);

    // Output stall: result held, no accept while HOLD
    do_reset();
    load_coefs(2, -4, 7);
    out_ready = 1'b0;
    run_sample("stall_first", -3, -6, 4, 1'b0, 0);
    in_valid = 1'b1; in_data = 8'sd9;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_data%0d", c), int'(a_out_data), -6);
      chk($sformatf("stall_valid%0d", c), int'(a_out_valid), 1);
      chk($sformatf("stall_in_ready%0d", c), int'(a_in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", int'(a_out_valid), 0);
    chk("stall_release_in_ready", int'(a_in_ready), 1);
    run_sample("stall_second", 9, 30, 4, 1'b0, 0);

    // Overflow: 18-bit exact, 16-bit wraps
    do_reset();
    load_coefs(-128, -128, -128);
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) run_sample($sformatf("ovf%0d", v), ovf[v].din, ovf[v].exp, 4, 1'b1, ovf[v].exp16);

    // Out-of-range config address ignored
    do_reset();
    load_coefs(2, -4, 7);
    out_ready = 1'b1;
    cfg_write(3, 55);
    run_sample("cfg_oob", -3, -6, 4, 1'b0, 0);

    // Config write while busy lands in the next IDLE cycle
    in_valid = 1'b1; in_data = 8'sd1;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      if (a_in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'sd5;
    done = 1'b0; got = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      if (a_out_valid) got = int'(a_out_data);
      if (a_busy) chk($sformatf("busy_cfg_ready%0d", t), int'(a_cfg_ready), 0);
      if (a_cfg_ready) done = 1'b1;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    chk("busy_cfg_done", int'(done), 1);
    chk("busy_cfg_old_coef_result", got, 14);
    run_sample("busy_cfg_new_coef", 0, -25, 4, 1'b0, 0);

    // Simultaneous sample and config write use the new coefficient
    do_reset();
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'sd3;
    run_sample("simul", 10, 30, 4, 1'b0, 0);

    // Reset during the second ISSUE cycle
    do_reset();
    load_coefs(1, 1, 1);
    out_ready = 1'b1;
    run_sample("pre_rst", 7, 7, 4, 1'b0, 0);
    in_valid = 1'b1; in_data = 8'sd6;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      if (a_in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_busy_before_rst", int'(a_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(a_out_valid), 0);
    chk("mid_rst_busy", int'(a_busy), 0);
    chk("mid_rst_out_data", int'(a_out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_valid", int'(a_out_valid), 0);
    run_sample("post_rst_zero_coef", 5, 0, 4, 1'b0, 0);
    load_coefs(1, 1, 1);
    run_sample("post_rst_delay_line", 0, 5, 4, 1'b0, 0);

    // Single-lane build: three rounds, latency 5
    sel1 = 1'b1;
    do_reset();
    load_coefs(1, 1, 1);
    out_ready = 1'b1;
    run_sample("n1_s1", 1, 1, 5, 1'b0, 0);
    run_sample("n1_s2", 2, 3, 5, 1'b0, 0);
    run_sample("n1_s3", 3, 6, 5, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Sequencing controller for a TAPS-tap signed FIR, y = x1*r1 + x2*r2 + ... + xTAPS*rTAPS, where x1 is the newest sample.
- Time-shares NMUL registered multiplier lanes across all taps in ceil(TAPS/NMUL) issue rounds and accumulates the partial products.
- Sample input and result output use valid/ready handshakes; coefficients are loaded through a small config port.
- Sits between the sample source and downstream filter consumers, replacing hand-wired one-hot stage strobes.

Parameters:
- TAPS, 3, number of filter taps and coefficient registers.
- NMUL, 2, number of shared multiplier lanes (1..TAPS).
- DW, 8, signed sample width.
- CW, 8, signed coefficient width.
- ACCW, 18, signed accumulator/result width (>= DW+CW).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample available.
- in_ready  out  1  scheduler accepts a sample.
- in_data  in  DW  signed sample.
- cfg_we  in  1  coefficient write request.
- cfg_ready  out  1  coefficient write accepted.
- cfg_addr  in  max(1,$clog2(TAPS))  coefficient index (0 selects r1).
- cfg_data  in  CW  signed coefficient.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  ACCW  signed filter output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n low) forces:
  - state IDLE;
  - delay line x1..xTAPS = 0;
  - coefficients r1..rTAPS = 0;
  - accumulator = 0, out_data = 0;
  - out_valid = 0, busy = 0.
- Reset asserted mid-operation aborts the computation; no partial result is ever presented.
- Define R = ceil(TAPS/NMUL).
- States: IDLE -> ISSUE (R cycles) -> DRAIN (1 cycle) -> HOLD -> IDLE.
- in_ready = cfg_ready = (state == IDLE). Both are registered-state decodes with no combinational path from inputs.
- Accept edge A (in_valid & in_ready):
  - delay line shifts: x1 <= in_data, xk <= x(k-1);
  - state <= ISSUE, round counter = 0, accumulator cleared.
- ISSUE round j (cycles A+1 .. A+R):
  - lane i gets operands x(j*NMUL+i+1) and r(j*NMUL+i+1);
  - lanes whose index exceeds TAPS get operands 0/0;
  - each lane registers its product (DW+CW signed) at the end of the issue cycle;
  - from round 1 on, the accumulator adds the sign-extended sum of the previous round's lane products.
- DRAIN (cycle A+R+1): adds the final round's products; out_data <= final sum; out_valid <= 1.
- out_valid is first high in cycle A+R+2. Latency from the accept edge is R+2 cycles (4 for the defaults).
- HOLD:
  - out_data and out_valid stay stable until out_ready is sampled high;
  - on that edge out_valid <= 0 and state <= IDLE.
- Back-to-back operation: in_valid held high gives a new accept in the first IDLE cycle. Throughput is one sample per R+3 cycles plus any out_ready stall.
- No sample is accepted in HOLD even if out_ready is high in the same cycle.
- Arithmetic: all operations signed two's complement. The accumulator wraps modulo 2^ACCW on overflow, with no saturation or flag.
- Config write (cfg_we & cfg_ready): r(cfg_addr+1) <= cfg_data.
  - cfg_addr >= TAPS: write ignored, no error.
  - Config writes while busy are not accepted; the requester holds cfg_we.
- A simultaneous in_valid and cfg_we in IDLE are both taken on the same edge. The sample's computation uses the updated coefficient.

Decomposition:
- Package fir_pkg holds:
  - default DW/CW/ACCW;
  - the state enum (IDLE, ISSUE, DRAIN, HOLD);
  - function rounds(TAPS, NMUL) = ceil division.
- Sub-module fir_mul_lane: one registered signed multiplier (clk, rst_n, a[DW], b[CW], p[DW+CW], p reset 0), instantiated NMUL times by generate.
- The delay line, coefficient bank, round counter and FSM stay in the top module.

Test Plan:
- Defaults; load r = 2, -4, 7; feed -3, 9, 4, -8, 2 with out_ready = 1 -> out_data = -6, 30, -49, 31, 64, each with out_valid first high 4 cycles after its accept edge.
- Same coefficients; hold out_ready = 0 for 5 cycles after the first result -> out_data stays -6, in_ready stays 0, and the next sample (9) is accepted only after the out_ready handshake.
- All coefficients -128, samples -128 three times -> third result = 49152 with no wrap. With ACCW = 16 the same stimulus -> -16384 (wrapped).
- cfg_we with addr 3 (TAPS = 3) -> coefficients unchanged. cfg_we while busy -> cfg_ready = 0 and the write lands in the next IDLE cycle.
- Deassert rst_n during the second ISSUE cycle -> out_valid, busy, out_data and the delay line are 0 immediately. After release, sample 5 with r = 0 gives result 0.
- NMUL = 1, TAPS = 3, r = 1, 1, 1, samples 1, 2, 3 -> results 1, 3, 6, with latency 5 cycles from accept.
